// File: rtl/peripheral_div_gen.sv
// peripheral_div_gen: memory-mapped iterative integer divider on the J1 I/O bus.
// Computes a W-bit quotient and remainder, signed or unsigned, one quotient bit
// per clock using restoring shift/subtract.
//
// Bus handshake: a register access happens on the rising edge where cs is high
// together with wr (write) or rd (read). There is no wait state: writes take
// effect on that edge, and read data appears on d_out after that edge and then
// holds until the next read.
module peripheral_div_gen #(
    parameter int W     = 16,
    parameter int BUS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS_W-1:0] d_in,
    input  logic             cs,
    input  logic [4:0]       addr,
    input  logic             rd,
    input  logic             wr,
    output logic [BUS_W-1:0] d_out,
    output logic             irq
);

    localparam logic [4:0] ADDR_A      = 5'h04;
    localparam logic [4:0] ADDR_B      = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;
    localparam logic [4:0] ADDR_QUOT   = 5'h10;
    localparam logic [4:0] ADDR_REM    = 5'h14;
    localparam logic [4:0] ADDR_STATUS = 5'h18;

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // programmer-visible registers
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sgn;
    logic          r_ie;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem;
    logic          r_done;
    logic          r_div0;

    // working registers of the divide loop
    logic [W-1:0]  r_dvd;      // dividend magnitude, shifts out MSB-first, quotient shifts in
    logic [W-1:0]  r_dvs;      // divisor magnitude
    logic [W-1:0]  r_pr;       // partial remainder
    logic [CW-1:0] r_cnt;
    logic          r_a_neg;
    logic          r_b_neg;
    logic          r_zero;

    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_busy;
    logic          w_start;
    logic          w_status_rd;
    logic [W-1:0]  w_a_mag;
    logic [W-1:0]  w_b_mag;
    logic [W:0]    w_shift;
    logic [W:0]    w_diff;
    logic          w_ge;
    logic [BUS_W-1:0] w_rd_data;
    logic          w_unused_bits;

    assign w_wr_en     = cs & wr;
    assign w_rd_en     = cs & rd;
    assign w_busy      = (r_state != ST_IDLE);
    assign w_start     = w_wr_en && (addr == ADDR_CTRL) && d_in[0] && !w_busy;
    assign w_status_rd = w_rd_en && (addr == ADDR_STATUS);
    assign irq         = r_done & r_ie;

    // Only the low W bits (and CTRL bits 2:0) of d_in carry meaning.
    assign w_unused_bits = ^d_in;

    // Magnitudes are only taken when the signed mode was latched for this run.
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_a_mag = (r_sgn && r_a[W-1]) ? -r_a : r_a;
    assign w_b_mag = (r_sgn && r_b[W-1]) ? -r_b : r_b;

    // One restoring step: bring in the next dividend bit, subtract when it fits.
    assign w_shift = {r_pr, r_dvd[W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[W];

    // Next-state decode for the divide sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next = ST_PREP;
            ST_PREP: w_next = (r_b == '0) ? ST_FIX : ST_CALC;
            ST_CALC: if (r_cnt == CW'(W - 1)) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Register writes, divide datapath and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sgn   <= 1'b0;
            r_ie    <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_pr    <= '0;
            r_cnt   <= '0;
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            // Operands and mode are frozen while a run is in progress; ie is not.
            if (w_wr_en && !w_busy && (addr == ADDR_A))    r_a   <= d_in[W-1:0];
            if (w_wr_en && !w_busy && (addr == ADDR_B))    r_b   <= d_in[W-1:0];
            if (w_wr_en && !w_busy && (addr == ADDR_CTRL)) r_sgn <= d_in[1];
            if (w_wr_en && (addr == ADDR_CTRL))            r_ie  <= d_in[2];

            // Reading STATUS acknowledges done; a completion on the same edge wins below.
            if (w_status_rd) r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_done <= 1'b0;
                        r_div0 <= 1'b0;
                    end
                end
                ST_PREP: begin
                    r_a_neg <= r_sgn & r_a[W-1];
                    r_b_neg <= r_sgn & r_b[W-1];
                    r_dvd   <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_pr    <= '0;
                    r_cnt   <= '0;
                    r_zero  <= (r_b == '0);
                end
                ST_CALC: begin
                    r_pr  <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
                    r_dvd <= {r_dvd[W-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    if (r_zero) begin
                        r_quot <= '1;
                        r_rem  <= r_a;
                        r_div0 <= 1'b1;
                    end else begin
                        r_quot <= (r_a_neg ^ r_b_neg) ? -r_dvd : r_dvd;
                        r_rem  <= r_a_neg ? -r_pr : r_pr;
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read-data selection, zero-extended to the bus width.
    always_comb begin
        w_rd_data = '0;
        case (addr)
            ADDR_QUOT:   w_rd_data[W-1:0] = r_quot;
            ADDR_REM:    w_rd_data[W-1:0] = r_rem;
            ADDR_STATUS: w_rd_data[2:0]   = {r_div0, w_busy, r_done};
            default:     w_rd_data = '0;
        endcase
    end

    // Registered read port: updates only on a read strobe, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset)        d_out <= '0;
        else if (w_rd_en) d_out <= w_rd_data;
    end

endmodule

// File: tb/tb_peripheral_div_gen.sv
// Bench for peripheral_div_gen: bus driver tasks, a reference divider built on
// plain integer arithmetic, and a read monitor checking d_out against a queue.
module tb_peripheral_div_gen;

    localparam int W     = 16;
    localparam int BUS_W = 32;

    localparam logic [4:0] RA_A      = 5'h04;
    localparam logic [4:0] RA_B      = 5'h08;
    localparam logic [4:0] RA_CTRL   = 5'h0C;
    localparam logic [4:0] RA_QUOT   = 5'h10;
    localparam logic [4:0] RA_REM    = 5'h14;
    localparam logic [4:0] RA_STATUS = 5'h18;
    localparam logic [4:0] RA_NONE   = 5'h1C;

    logic             clk = 1'b0;
    logic             reset;
    logic [BUS_W-1:0] d_in;
    logic             cs;
    logic [4:0]       addr;
    logic             rd;
    logic             wr;
    logic [BUS_W-1:0] d_out;
    logic             irq;

    int total = 0;
    int bad   = 0;

    logic [BUS_W-1:0] exp_q[$];
    string            name_q[$];
    logic             rd_seen = 1'b0;

    peripheral_div_gen #(.W(W), .BUS_W(BUS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .irq   (irq)
    );

    // clock / reset
    always #5 clk = ~clk;

    // remember which edges carried a read strobe
    always @(posedge clk) rd_seen <= cs & rd & ~reset;

    // monitor: each read's data is compared with the oldest expected entry
    always @(negedge clk) begin
        if (rd_seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL read_unexpected got=%h (no expected entry)", d_out);
            end else begin
                logic [BUS_W-1:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (d_out !== e) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", nm, d_out, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // reference: integer division truncating toward zero, remainder follows dividend
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            z  = 1'b0;
        end
    endfunction

    // driver tasks: called at a falling edge, return at the next falling edge
    task automatic bus_wr(input logic [4:0] a, input logic [BUS_W-1:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = '0;
    endtask

    task automatic bus_rd(input logic [4:0] a, input logic [BUS_W-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [BUS_W-1:0] ctrl(input logic ie, input logic sgn, input logic start);
        logic [BUS_W-1:0] v;
        v = '0;
        v[2:0] = {ie, sgn, start};
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] ext(input logic [W-1:0] v);
        logic [BUS_W-1:0] x;
        x = '0;
        x[W-1:0] = v;
        return x;
    endfunction

    // wait for irq, counting falling edges since the start edge; bounded
    task automatic wait_irq(input int k0, input int lat, input string nm);
        int k;
        k = k0;
        while (!irq && k < W + 20) begin
            @(negedge clk);
            k++;
        end
        check(nm, k, lat);
    endtask

    // one full operation through the register interface
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input logic ie);
        logic [W-1:0] q, r;
        logic z;
        int lat;
        model(a, b, sgn, q, r, z);
        lat = z ? 2 : W + 2;
        bus_wr(RA_A, ext(a));
        bus_wr(RA_B, ext(b));
        bus_wr(RA_CTRL, ctrl(ie, sgn, 1'b1));
        bus_rd(RA_STATUS, 32'h2, "status_busy");
        if (ie) begin
            wait_irq(1, lat, "done_latency");
        end else begin
            idle(lat);
            check("irq_masked", irq, 0);
        end
        bus_rd(RA_QUOT, ext(q), "quot");
        bus_rd(RA_REM, ext(r), "rem");
        bus_rd(RA_STATUS, {29'b0, z, 2'b01}, "status_done");
        bus_rd(RA_STATUS, {29'b0, z, 2'b00}, "status_cleared");
        check("irq_after_clear", irq, 0);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        idle(3);
        reset = 1'b0;
        check("reset_d_out", d_out, 0);
        check("reset_irq", irq, 0);
        bus_rd(RA_STATUS, 32'h0, "reset_status");
        bus_rd(RA_QUOT, 32'h0, "reset_quot");
        bus_rd(RA_REM, 32'h0, "reset_rem");

        // directed operations
        run_op(16'd100, 16'd7, 1'b0, 1'b1);
        run_op(16'hFF9C, 16'd7, 1'b1, 1'b1);
        run_op(16'h8000, 16'hFFFF, 1'b1, 1'b1);
        run_op(16'd5, 16'd0, 1'b0, 1'b1);
        run_op(16'd1000, 16'd33, 1'b0, 1'b0);
        run_op(16'h8000, 16'hFFFF, 1'b0, 1'b1);
        run_op(16'd7, 16'hFFF9, 1'b1, 1'b1);

        // unmapped and write-only offsets read as zero
        bus_rd(RA_NONE, 32'h0, "read_unmapped");
        bus_rd(RA_A, 32'h0, "read_write_only");

        // writes and start during busy are ignored; exactly one completion
        bus_wr(RA_A, ext(16'd100));
        bus_wr(RA_B, ext(16'd7));
        bus_wr(RA_CTRL, ctrl(1'b1, 1'b0, 1'b1));
        bus_wr(RA_A, ext(16'd9));
        bus_wr(RA_CTRL, ctrl(1'b1, 1'b1, 1'b1));
        bus_wr(RA_B, ext(16'd1));
        wait_irq(3, W + 2, "busy_done_latency");
        bus_rd(RA_QUOT, 32'd14, "busy_quot");
        bus_rd(RA_REM, 32'd2, "busy_rem");
        bus_rd(RA_STATUS, 32'h1, "busy_status_done");
        idle(W + 4);
        check("busy_no_second_irq", irq, 0);
        bus_rd(RA_STATUS, 32'h0, "busy_no_second_done");

        // STATUS read on the completion edge does not lose done
        bus_wr(RA_CTRL, ctrl(1'b1, 1'b0, 1'b1));
        idle(W + 1);
        bus_rd(RA_STATUS, 32'h2, "status_on_done_edge");
        check("done_kept_irq", irq, 1);
        bus_rd(RA_STATUS, 32'h1, "done_kept_status");
        check("done_kept_cleared_irq", irq, 0);

        // done is sticky while masked, irq appears when ie is set afterwards
        bus_wr(RA_CTRL, ctrl(1'b0, 1'b0, 1'b1));
        idle(W + 4);
        check("masked_irq_low", irq, 0);
        bus_wr(RA_CTRL, ctrl(1'b1, 1'b0, 1'b0));
        check("unmask_irq_high", irq, 1);
        bus_rd(RA_STATUS, 32'h1, "unmask_status");

        // reset in the middle of CALC
        bus_wr(RA_A, ext(16'd1234));
        bus_wr(RA_B, ext(16'd10));
        bus_wr(RA_CTRL, ctrl(1'b1, 1'b0, 1'b1));
        bus_rd(RA_STATUS, 32'h2, "pre_reset_status");
        idle(4);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midreset_d_out", d_out, 0);
        check("midreset_irq", irq, 0);
        bus_rd(RA_STATUS, 32'h0, "midreset_status");
        bus_rd(RA_QUOT, 32'h0, "midreset_quot");
        bus_rd(RA_REM, 32'h0, "midreset_rem");
        // A and B were cleared, so a bare start is a 0/0 division
        bus_wr(RA_CTRL, ctrl(1'b0, 1'b0, 1'b1));
        idle(3);
        bus_rd(RA_QUOT, 32'hFFFF, "post_reset_zero_quot");
        bus_rd(RA_REM, 32'h0, "post_reset_zero_rem");
        bus_rd(RA_STATUS, 32'h5, "post_reset_zero_status");
        run_op(16'd100, 16'd7, 1'b0, 1'b1);

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            int sel;
            a   = W'($urandom_range(0, 65535));
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = '0;
                1:       b = '1;
                2:       b = W'(1);
                3:       b = W'($urandom_range(1, 15));
                default: b = W'($urandom_range(0, 65535));
            endcase
            if (sel == 4) a = 16'h8000;
            run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end

        idle(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
